// File: rtl/ds_synapse.sv
// Spike-driven synapse: edge-detected presynaptic events add or subtract a
// weight from a conductance register that decays exponentially on a
// prescaled tick. The registered conductance drives a LIF neuron's syn_i.
module ds_synapse #(
  parameter int unsigned W  = 14,
  parameter int unsigned PW = 16
) (
  input  logic          clk_in,
  input  logic          reset_n,
  input  logic          pre_spike,
  input  logic [W-1:0]  weight,
  input  logic          excit,
  input  logic [3:0]    decay_shift,
  input  logic [PW-1:0] decay_period,
  input  logic          cnt_clr,
  output logic [W-1:0]  syn_o,
  output logic          sat,
  output logic [PW-1:0] spike_cnt
);

  logic          pre_q;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [W-1:0]  g_q, g_d;
  logic          sat_q, sat_d;
  logic [PW-1:0] cnt_q, cnt_d;

  logic          evt;
  logic          tick;
  logic [W-1:0]  dec;
  logic [W-1:0]  gd;
  logic [W:0]    sum;

  assign evt  = pre_spike & ~pre_q;
  assign tick = (decay_period != '0) && (pcnt_q == decay_period - PW'(1));

  // Prescaler: a period shorter than the current count runs on to the
  // natural PW-bit wrap before it can match again.
  always_comb begin
    pcnt_d = pcnt_q + PW'(1);
    if (decay_period == '0) begin
      pcnt_d = '0;
    end else if (tick) begin
      pcnt_d = '0;
    end
  end

  // Decay first, then apply the event weight to the decayed value.
  always_comb begin
    dec = g_q >> decay_shift;
    // Force a minimum step of 1 so small conductances still reach zero.
    if (dec == '0 && g_q != '0) begin
      dec = W'(1);
    end
    gd    = tick ? (g_q - dec) : g_q;
    sum   = {1'b0, gd} + {1'b0, weight};
    g_d   = gd;
    sat_d = 1'b0;
    if (evt) begin
      if (excit) begin
        if (sum[W]) begin
          g_d   = '1;
          sat_d = 1'b1;
        end else begin
          g_d = sum[W-1:0];
        end
      end else begin
        g_d = (weight >= gd) ? '0 : (gd - weight);
      end
    end
  end

  // Event counter: clear wins over a coincident event; saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (evt && (cnt_q != '1)) begin
      cnt_d = cnt_q + PW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      pre_q  <= 1'b0;
      pcnt_q <= '0;
      g_q    <= '0;
      sat_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pre_q  <= pre_spike;
      pcnt_q <= pcnt_d;
      g_q    <= g_d;
      sat_q  <= sat_d;
      cnt_q  <= cnt_d;
    end
  end

  assign syn_o     = g_q;
  assign sat       = sat_q;
  assign spike_cnt = cnt_q;

endmodule

// File: tb/tb_ds_synapse.sv
// Bench for ds_synapse: a directed vector table, hand-written corner-case
// sequences with constant expectations, and randomized stimulus compared
// cycle by cycle against an integer reference model.
module tb_ds_synapse;

  localparam int GMAX = 16383;
  localparam int CMAX = 65535;

  logic        clk;
  logic        t_rst;
  logic        t_pre;
  logic [13:0] t_w;
  logic        t_ex;
  logic [3:0]  t_sh;
  logic [15:0] t_per;
  logic        t_clr;
  logic [13:0] syn_o;
  logic        sat;
  logic [15:0] spike_cnt;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  int m_g, m_pcnt, m_cnt;
  bit m_pre, m_sat;

  ds_synapse #(.W(14), .PW(16)) dut (
    .clk_in       (clk),
    .reset_n      (t_rst),
    .pre_spike    (t_pre),
    .weight       (t_w),
    .excit        (t_ex),
    .decay_shift  (t_sh),
    .decay_period (t_per),
    .cnt_clr      (t_clr),
    .syn_o        (syn_o),
    .sat          (sat),
    .spike_cnt    (spike_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of the behavioural model, from the inputs present at the edge.
  task automatic model_edge();
    bit evt, tick;
    int g, d, per;
    per = int'(t_per);
    if (!t_rst) begin
      m_g = 0; m_pre = 0; m_pcnt = 0; m_sat = 0; m_cnt = 0;
      return;
    end
    evt  = t_pre && !m_pre;
    tick = (per != 0) && (m_pcnt == per - 1);
    g = m_g;
    if (tick) begin
      d = g / (1 << int'(t_sh));
      if (d == 0 && g > 0) d = 1;
      g = g - d;
    end
    m_sat = 0;
    if (evt) begin
      if (t_ex) begin
        if (g + int'(t_w) > GMAX) begin
          g = GMAX;
          m_sat = 1;
        end else begin
          g = g + int'(t_w);
        end
      end else begin
        g = (int'(t_w) >= g) ? 0 : g - int'(t_w);
      end
    end
    m_g = g;
    if (per == 0 || tick) m_pcnt = 0;
    else m_pcnt = (m_pcnt + 1) % 65536;
    if (t_clr) m_cnt = 0;
    else if (evt && m_cnt < CMAX) m_cnt = m_cnt + 1;
    m_pre = t_pre;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".syn"}, 32'(syn_o), 32'(m_g));
    chk({tag, ".sat"}, 32'(sat), 32'(m_sat));
    chk({tag, ".cnt"}, 32'(spike_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    t_rst = 1'b0; t_pre = 1'b0; t_clr = 1'b0; t_per = '0; t_sh = '0;
    step("rst");
    t_rst = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    bit          pre;
    logic [13:0] w;
    bit          ex;
    bit          clr;
    int          e_syn;
    bit          e_sat;
    int          e_cnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    t_rst = 1'b0; t_pre = 1'b0; t_w = '0; t_ex = 1'b1;
    t_sh = '0; t_per = '0; t_clr = 1'b0;

    // Reset, accumulation, saturation, inhibitory floor, level hold, clear
    tbl[0]  = '{0, 0,     0, 1, 0,     0, 0, 0};
    tbl[1]  = '{1, 1,  1000, 1, 0,  1000, 0, 1};
    tbl[2]  = '{1, 0,  1000, 1, 0,  1000, 0, 1};
    tbl[3]  = '{1, 0,  1000, 1, 0,  1000, 0, 1};
    tbl[4]  = '{1, 0,  1000, 1, 0,  1000, 0, 1};
    tbl[5]  = '{1, 1,  1000, 1, 0,  2000, 0, 2};
    tbl[6]  = '{1, 0,  1000, 1, 0,  2000, 0, 2};
    tbl[7]  = '{1, 0,  1000, 1, 0,  2000, 0, 2};
    tbl[8]  = '{1, 0,  1000, 1, 0,  2000, 0, 2};
    tbl[9]  = '{1, 1,  1000, 1, 0,  3000, 0, 3};
    tbl[10] = '{1, 0, 10000, 1, 0,  3000, 0, 3};
    tbl[11] = '{1, 1, 10000, 1, 0, 13000, 0, 4};
    tbl[12] = '{1, 0, 10000, 1, 0, 13000, 0, 4};
    tbl[13] = '{1, 1, 10000, 1, 0, 16383, 1, 5};
    tbl[14] = '{1, 0, 10000, 1, 0, 16383, 0, 5};
    tbl[15] = '{1, 1, 16383, 0, 0,     0, 0, 6};
    tbl[16] = '{1, 1,     5, 1, 0,     0, 0, 6};
    tbl[17] = '{1, 0,     5, 1, 1,     0, 0, 0};

    for (int i = 0; i < 18; i++) begin
      t_rst = tbl[i].rst; t_pre = tbl[i].pre; t_w = tbl[i].w;
      t_ex = tbl[i].ex; t_clr = tbl[i].clr; t_per = '0; t_sh = '0;
      step("tbl");
      chk($sformatf("tbl[%0d].syn", i), 32'(syn_o), 32'(tbl[i].e_syn));
      chk($sformatf("tbl[%0d].sat", i), 32'(sat), 32'(tbl[i].e_sat));
      chk($sformatf("tbl[%0d].cnt", i), 32'(spike_cnt), 32'(tbl[i].e_cnt));
    end

    // Level held high for 10 cycles adds once
    do_reset();
    t_w = 14'd100; t_ex = 1'b1; t_pre = 1'b1;
    repeat (10) step("hold");
    chk("hold.syn", 32'(syn_o), 32'd100);
    chk("hold.cnt", 32'(spike_cnt), 32'd1);

    // Decay 1024 -> 512 -> 256 with shift 1, period 4
    do_reset();
    t_w = 14'd1024; t_pre = 1'b1; step("dec");
    t_pre = 1'b0; t_sh = 4'd1; t_per = 16'd4;
    repeat (3) step("dec");
    chk("dec.pre_tick", 32'(syn_o), 32'd1024);
    step("dec");
    chk("dec.t1", 32'(syn_o), 32'd512);
    repeat (4) step("dec");
    chk("dec.t2", 32'(syn_o), 32'd256);

    // Small conductance still reaches zero: 3 -> 2 -> 1 -> 0 -> 0
    do_reset();
    t_w = 14'd3; t_pre = 1'b1; step("small");
    t_pre = 1'b0; t_sh = 4'd4; t_per = 16'd1;
    step("small"); chk("small.2", 32'(syn_o), 32'd2);
    step("small"); chk("small.1", 32'(syn_o), 32'd1);
    step("small"); chk("small.0", 32'(syn_o), 32'd0);
    step("small"); chk("small.hold0", 32'(syn_o), 32'd0);

    // Inhibitory floor and partial subtraction
    do_reset();
    t_w = 14'd500; t_ex = 1'b1; t_pre = 1'b1; step("inh");
    t_pre = 1'b0; step("inh");
    t_w = 14'd800; t_ex = 1'b0; t_pre = 1'b1; step("inh");
    chk("inh.floor", 32'(syn_o), 32'd0);
    chk("inh.nosat", 32'(sat), 32'd0);
    do_reset();
    t_w = 14'd500; t_ex = 1'b1; t_pre = 1'b1; step("inh");
    t_pre = 1'b0; step("inh");
    t_w = 14'd200; t_ex = 1'b0; t_pre = 1'b1; step("inh");
    chk("inh.sub", 32'(syn_o), 32'd300);

    // Tick and event on the same edge: 1000 - 250 + 100
    do_reset();
    t_w = 14'd1000; t_ex = 1'b1; t_pre = 1'b1; step("sim");
    t_pre = 1'b0; t_sh = 4'd2; t_per = 16'd5;
    repeat (4) step("sim");
    chk("sim.pre", 32'(syn_o), 32'd1000);
    t_w = 14'd100; t_pre = 1'b1; step("sim");
    chk("sim.both", 32'(syn_o), 32'd850);

    // Reset mid-operation discards g and restarts the prescaler
    do_reset();
    t_w = 14'd5000; t_ex = 1'b1; t_pre = 1'b1; step("mid");
    chk("mid.g", 32'(syn_o), 32'd5000);
    t_pre = 1'b0; t_sh = 4'd1; t_per = 16'd3;
    repeat (2) step("mid");
    t_rst = 1'b0; step("mid");
    chk("mid.rst_syn", 32'(syn_o), 32'd0);
    chk("mid.rst_cnt", 32'(spike_cnt), 32'd0);
    t_rst = 1'b1; t_w = 14'd800; t_pre = 1'b1; step("mid");
    chk("mid.ev", 32'(syn_o), 32'd800);
    t_pre = 1'b0; step("mid");
    chk("mid.notick", 32'(syn_o), 32'd800);
    step("mid");
    chk("mid.tick", 32'(syn_o), 32'd400);

    // Counter clear beats a coincident event
    do_reset();
    t_w = 14'd1; t_ex = 1'b1; t_pre = 1'b1; step("clr");
    t_pre = 1'b0; step("clr");
    t_pre = 1'b1; t_clr = 1'b1; step("clr");
    chk("clr.evt", 32'(spike_cnt), 32'd0);
    t_pre = 1'b0; t_clr = 1'b0; step("clr");
    t_pre = 1'b1; step("clr");
    chk("clr.after", 32'(spike_cnt), 32'd1);

    // Randomized stimulus against the model; period only changes on reset
    for (int i = 0; i < 3000; i++) begin
      t_rst = ($urandom_range(0, 149) != 0);
      if (!t_rst) t_per = 16'($urandom_range(0, 12));
      t_pre = ($urandom_range(0, 9) < 4);
      t_w   = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(8000, 16383))
                                          : 14'($urandom_range(0, 2000));
      t_ex  = ($urandom_range(0, 3) != 0);
      t_sh  = 4'($urandom_range(0, 15));
      t_clr = ($urandom_range(0, 49) == 0);
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
